keypad_letter_fsm: RTL and testbench

// - Sequencer downstream of the keypad scanner: consumes {row,col} key codes plus strobe.
// - Turns multi-tap presses on keys 2-9 into uppercase ASCII letters for the hangman guess path.
// - Owns key acceptance: press lockout, confirm (#), cancel (*), optional inactivity auto-commit.

---
 rtl/keypad_letter_fsm.sv | 229 ++++++++++++++++++++++
 tb/tb_keypad_letter_fsm.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_letter_fsm.sv
// -----------------------------------------------------------------------------
// keypad_letter_fsm
//
// Multi-tap letter sequencer that sits after the keypad scanner. Presses on
// keys 2-9 cycle through that key's letter group. The pending letter is
// committed as uppercase ASCII on '#', or when a different letter key is
// pressed. '*' discards the pending letter.
//
// Strobes are subject to a press lockout of LOCKOUT_CYCLES enabled cycles
// after each accepted strobe.
//
// Optional feature (macro KEYPAD_AUTOCOMMIT_EN): commit the pending letter
// automatically after TIMEOUT_CYCLES idle cycles in PEND.
//
// Ports
//   clk        in   1  system clock, all logic on posedge
//   rst        in   1  asynchronous, active-high reset
//   enable     in   1  1 = strobes accepted / timeout counts, 0 = frozen
//   cur_key    in   8  [7:4] row one-hot (bit7 top row),
//                      [3:0] col one-hot (bit3 left col)
//   strobe     in   1  one-cycle press edge qualifying cur_key
//   letter     out  8  ASCII of last committed letter, held until next commit
//   letter_vld out  1  one-cycle pulse; letter carries the new value in
//                      the same cycle
//   preview    out  8  ASCII of pending candidate, 8'h00 outside PEND
//   busy       out  1  high while a candidate is pending
//   key_err    out  1  one-cycle pulse for an accepted strobe whose key
//                      code is malformed
//
// Handshake: there is no back-pressure. letter_vld and key_err are
// single-cycle valid pulses that the consumer must take in the cycle they
// are high. All outputs are registered and change on the cycle after the
// accepted strobe.
// -----------------------------------------------------------------------------
module keypad_letter_fsm #(
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] cur_key,
    input  logic       strobe,
    output logic [7:0] letter,
    output logic       letter_vld,
    output logic [7:0] preview,
    output logic       busy,
    output logic       key_err
);

    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
        $error("LOCKOUT_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // ---------------------------------------------------------------- helpers
    function automatic logic onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Position of the set bit, counted from the MSB (top row / left col = 0).
    function automatic logic [1:0] pos4(input logic [3:0] v);
        case (v)
            4'b1000: pos4 = 2'd0;
            4'b0100: pos4 = 2'd1;
            4'b0010: pos4 = 2'd2;
            default: pos4 = 2'd3;
        endcase
    endfunction

    function automatic logic [7:0] group_base(input logic [3:0] d);
        case (d)
            4'd2:    group_base = 8'h41; // A
            4'd3:    group_base = 8'h44; // D
            4'd4:    group_base = 8'h47; // G
            4'd5:    group_base = 8'h4A; // J
            4'd6:    group_base = 8'h4D; // M
            4'd7:    group_base = 8'h50; // P
            4'd8:    group_base = 8'h54; // T
            4'd9:    group_base = 8'h57; // W
            default: group_base = 8'h00;
        endcase
    endfunction

    // Highest index in a group: 7 and 9 carry four letters, the rest three.
    function automatic logic [1:0] group_last(input logic [3:0] d);
        return ((d == 4'd7) || (d == 4'd9)) ? 2'd3 : 2'd2;
    endfunction

    // -------------------------------------------------------------- registers
    state_t            state, state_n;
    logic [3:0]        grp, grp_n;
    logic [1:0]        idx, idx_n;
    logic [LOCK_W-1:0] lock_cnt, lock_n;
    logic [7:0]        letter_n, preview_n;
    logic              letter_vld_n, busy_n, key_err_n;

    // ------------------------------------------------------------- key decode
    logic       key_ok, is_letter, is_hash, is_star, accept, commit;
    logic [1:0] row, col;
    logic [3:0] key_digit;
    logic [7:0] cand;

    always_comb begin
        key_ok    = onehot4(cur_key[7:4]) && onehot4(cur_key[3:0]);
        row       = pos4(cur_key[7:4]);
        col       = pos4(cur_key[3:0]);
        // Digit of the 3x3 numeric block; only meaningful when row,col < 3.
        key_digit = 4'(row) * 4'd3 + 4'(col) + 4'd1;
        is_letter = key_ok && (row != 2'd3) && (col != 2'd3) && (key_digit != 4'd1);
        is_star   = key_ok && (row == 2'd3) && (col == 2'd0);
        is_hash   = key_ok && (row == 2'd3) && (col == 2'd2);
        accept    = strobe && enable && (lock_cnt == '0);
        cand      = group_base(grp) + {6'd0, idx};
    end

`ifdef KEYPAD_AUTOCOMMIT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt, to_n;
`endif

    // ------------------------------------------------------ next-state logic
    always_comb begin
        state_n   = state;
        grp_n     = grp;
        idx_n     = idx;
        lock_n    = lock_cnt;
        commit    = 1'b0;
        key_err_n = 1'b0;
`ifdef KEYPAD_AUTOCOMMIT_EN
        to_n      = to_cnt;
`endif

        if (enable && (lock_cnt != '0)) begin
            lock_n = lock_cnt - LOCK_W'(1);
        end

        if (accept) begin
            lock_n = LOCK_W'(LOCKOUT_CYCLES - 1);
            if (!key_ok) begin
                // Malformed code: flagged, otherwise behaves as an ignored key.
                key_err_n = 1'b1;
            end else if (is_letter) begin
                if (state == IDLE) begin
                    state_n = PEND;
                    grp_n   = key_digit;
                    idx_n   = 2'd0;
                end else if (key_digit == grp) begin
                    idx_n = (idx == group_last(grp)) ? 2'd0 : idx + 2'd1;
                end else begin
                    commit = 1'b1;
                    grp_n  = key_digit;
                    idx_n  = 2'd0;
                end
            end else if (is_hash && (state == PEND)) begin
                commit  = 1'b1;
                state_n = IDLE;
            end else if (is_star) begin
                state_n = IDLE;
            end
        end

`ifdef KEYPAD_AUTOCOMMIT_EN
        // Any accepted strobe (ignored keys included) restarts the idle
        // count, and takes priority over a timeout in the same cycle.
        if (accept || (state == IDLE)) begin
            to_n = '0;
        end else if (enable) begin
            if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                commit  = 1'b1;
                state_n = IDLE;
                to_n    = '0;
            end else begin
                to_n = to_cnt + TO_W'(1);
            end
        end
`endif

        letter_n     = commit ? cand : letter;
        letter_vld_n = commit;
        busy_n       = (state_n == PEND);
        preview_n    = (state_n == PEND) ? (group_base(grp_n) + {6'd0, idx_n}) : 8'h00;
    end

    // ---------------------------------------------------------- state update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grp        <= 4'd0;
            idx        <= 2'd0;
            lock_cnt   <= '0;
            letter     <= 8'h00;
            letter_vld <= 1'b0;
            preview    <= 8'h00;
            busy       <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            state      <= state_n;
            grp        <= grp_n;
            idx        <= idx_n;
            lock_cnt   <= lock_n;
            letter     <= letter_n;
            letter_vld <= letter_vld_n;
            preview    <= preview_n;
            busy       <= busy_n;
            key_err    <= key_err_n;
        end
    end

`ifdef KEYPAD_AUTOCOMMIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_n;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_letter_fsm.sv
// -----------------------------------------------------------------------------
// tb_keypad_letter_fsm
//
// Testbench for keypad_letter_fsm.
//
// A behavioural keypad model (character layout table plus letter-group
// strings) predicts every committed letter and error pulse, and pushes the
// predictions into expected queues. A monitor pops those queues whenever
// the DUT pulses. busy and preview are compared against the model after
// every press.
// -----------------------------------------------------------------------------
module tb_keypad_letter_fsm;

    localparam int LOCKOUT = 16;
    localparam int TIMEOUT = 1000;

    // ------------------------------------------------------ clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] cur_key = 8'h00;
    logic       strobe = 1'b0;
    logic [7:0] letter, preview;
    logic       letter_vld, busy, key_err;

    always #5 clk = ~clk;

    keypad_letter_fsm #(
        .LOCKOUT_CYCLES(LOCKOUT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cur_key   (cur_key),
        .strobe    (strobe),
        .letter    (letter),
        .letter_vld(letter_vld),
        .preview   (preview),
        .busy      (busy),
        .key_err   (key_err)
    );

    // --------------------------------------------------------- scoreboard
    logic [7:0] exp_q[$];
    logic [0:0] err_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------------------------------------------- reference model
    string layout = "123A456B789C*0#D";
    string grp_tab[10] = '{"", "", "ABC", "DEF", "GHI", "JKL", "MNO", "PQRS", "TUV", "WXYZ"};

    bit  m_pend = 0;
    byte m_key  = 0;
    int  m_taps = 0;
    int  m_lock = 0;
    int  m_idle = 0;

    function automatic logic [7:0] m_cand();
        string s;
        if (!m_pend) return 8'h00;
        s = grp_tab[m_key - "0"];
        return 8'(s[m_taps % s.len()]);
    endfunction

    function automatic void model_press(input logic [7:0] k);
        int  r, c;
        byte ch;
        if ($countones(k[7:4]) != 1 || $countones(k[3:0]) != 1) begin
            err_q.push_back(1'b1);
            return;
        end
        r = 0;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            if (k[7-i]) r = i;
            if (k[3-i]) c = i;
        end
        ch = layout[r*4 + c];
        if (ch >= "2" && ch <= "9") begin
            if (!m_pend) begin
                m_pend = 1;
                m_key  = ch;
                m_taps = 0;
            end else if (ch == m_key) begin
                m_taps++;
            end else begin
                exp_q.push_back(m_cand());
                m_key  = ch;
                m_taps = 0;
            end
        end else if (ch == "#") begin
            if (m_pend) exp_q.push_back(m_cand());
            m_pend = 0;
        end else if (ch == "*") begin
            m_pend = 0;
        end
    endfunction

    // One clock edge: model decides acceptance from the inputs in force at
    // the edge, then the bench waits until just after the edge.
    task automatic tick();
        bit acc;
        acc = strobe && enable && (m_lock == 0);
        if (acc) model_press(cur_key);
`ifdef KEYPAD_AUTOCOMMIT_EN
        if (acc) begin
            m_idle = 0;
        end else if (enable && m_pend) begin
            if (m_idle == TIMEOUT - 1) begin
                exp_q.push_back(m_cand());
                m_pend = 0;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
`endif
        @(posedge clk);
        #1;
        if (enable) m_lock = acc ? LOCKOUT - 1 : (m_lock > 0 ? m_lock - 1 : 0);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(m_pend));
        chk({tag, "_preview"}, 32'(preview), 32'(m_cand()));
    endtask

    task automatic press(input logic [7:0] k, input int gap);
        cur_key = k;
        strobe  = 1'b1;
        tick();
        strobe  = 1'b0;
        cur_key = 8'h00;
        check_outputs("press");
        for (int i = 1; i < gap; i++) tick();
    endtask

    task automatic check_drained(input string tag);
        repeat (2) tick();
        chk({tag, "_letters_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_errs_left"}, 32'(err_q.size()), 32'd0);
    endtask

    // ---------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (letter_vld) begin
                if (exp_q.size() == 0) chk("unexpected_letter_vld", 32'(letter), 32'hFFFF_FFFF);
                else chk("letter", 32'(letter), 32'(exp_q.pop_front()));
            end
            if (key_err) begin
                if (err_q.size() == 0) chk("unexpected_key_err", 32'd1, 32'd0);
                else chk("key_err", 32'd1, 32'(err_q.pop_front()));
            end
        end
    end

    // ---------------------------------------------------- random stimulus
    function automatic logic [7:0] mk_key(input int r, input int c);
        logic [3:0] one;
        one = 4'b1000;
        return {one >> r, one >> c};
    endfunction

    function automatic logic [7:0] rand_key(input logic [7:0] last);
        int         sel, d;
        logic [7:0] bad[4];
        bad = '{8'hC4, 8'h00, 8'h8F, 8'h30};
        sel = $urandom_range(0, 19);
        if (sel < 7 && last != 8'h00) return last;
        if (sel < 14) begin
            d = $urandom_range(2, 9);
            return mk_key((d - 1) / 3, (d - 1) % 3);
        end
        if (sel < 18) return mk_key($urandom_range(0, 3), $urandom_range(0, 3));
        return bad[$urandom_range(0, 3)];
    endfunction

    // --------------------------------------------------------- main flow
    initial begin
        logic [7:0] k;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_letter", 32'(letter), 32'h00);
        chk("rst_vld", 32'(letter_vld), 32'd0);
        chk("rst_preview", 32'(preview), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(key_err), 32'd0);
        rst = 1'b0;
        tick();

        // 2,2,# -> 'B'.
        press(8'h84, 20);
        press(8'h84, 20);
        chk("b_preview", 32'(preview), 32'h42);
        press(8'h12, 20);
        chk("b_letter", 32'(letter), 32'h42);
        check_drained("seq_b");

        // 7 x5 then # -> 'P' (wrap mod 4).
        for (int i = 0; i < 5; i++) press(8'h28, 20);
        press(8'h12, 20);
        chk("p_letter", 32'(letter), 32'h50);
        check_drained("seq_p");

        // 2 then 3 -> commit 'A', preview 'D'.
        press(8'h84, 20);
        press(8'h82, 20);
        chk("a_letter", 32'(letter), 32'h41);
        chk("d_preview", 32'(preview), 32'h44);
        chk("d_busy", 32'(busy), 32'd1);
        press(8'h18, 20);
        chk("star_busy", 32'(busy), 32'd0);

        // Malformed key in IDLE.
        press(8'hC4, 20);
        chk("err_busy", 32'(busy), 32'd0);
        check_drained("seq_err");

        // Lockout: second press at +5 ignored.
        press(8'h84, 5);
        press(8'h84, 20);
        chk("lock_preview", 32'(preview), 32'h41);
        press(8'h12, 20);
        chk("lock_letter", 32'(letter), 32'h41);
        check_drained("seq_lock");

        // enable low: strobes ignored, state frozen.
        press(8'h84, 20);
        enable = 1'b0;
        press(8'h84, 20);
        press(8'h12, 30);
        chk("en_preview", 32'(preview), 32'h41);
        chk("en_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        press(8'h18, 20);
        check_drained("seq_en");

        // Inactivity: with auto-commit the letter appears after TIMEOUT.
        press(8'h84, 1);
        repeat (TIMEOUT - 1) tick();
        chk("to_busy_before", 32'(busy), 32'd1);
        tick();
`ifdef KEYPAD_AUTOCOMMIT_EN
        chk("to_busy_after", 32'(busy), 32'd0);
        check_drained("seq_to");
        chk("to_letter", 32'(letter), 32'h41);
`else
        repeat (2000) tick();
        chk("to_busy_after", 32'(busy), 32'd1);
        check_drained("seq_to");
        press(8'h18, 20);
`endif

        // Randomized presses with random spacing.
        k = 8'h00;
        for (int n = 0; n < 120; n++) begin
            k = rand_key(k);
            press(k, $urandom_range(1, 40));
        end
        press(8'h18, 20);
        check_drained("random");

        // Reset in the middle of PEND: no pulse, outputs cleared.
        press(8'h84, 5);
        rst = 1'b1;
        #2;
        chk("mid_rst_letter", 32'(letter), 32'h00);
        chk("mid_rst_preview", 32'(preview), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_vld", 32'(letter_vld), 32'd0);
        m_pend = 0;
        m_lock = 0;
        m_idle = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_drained("seq_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $finish;
    end

endmodule
